// File: rtl/cp_removal_deserializer_if.sv
// ---------------------------------------------------------------------------
// cp_removal_deserializer_if
//   Bundles the serial receive link and the parallel sample outputs of the
//   CP-removal deserializer.
//
//   Serial side (driven by the link / master):
//     serialIn    serial data bit, MSB first
//     inValid     qualifies serialIn; a bit is accepted only when high
//     frameStart  marks the first bit of a frame (meaningful with inValid)
//   Parallel side (driven by the deserializer / slave):
//     out0R/out0I sample 0 real / imaginary
//     out1R/out1I sample 1 real / imaginary
//     outValid    one-cycle strobe, out* hold a new frame
//     cpErr       CP mismatch flag, valid with outValid
//     resync      one-cycle pulse when a frame is aborted by a new frameStart
//     busy        high while a frame is being received
//     bitCount    accepted-bit index within the current frame (debug)
// ---------------------------------------------------------------------------
interface cp_removal_deserializer_if;
    logic        serialIn;
    logic        inValid;
    logic        frameStart;
    logic [15:0] out0R;
    logic [15:0] out0I;
    logic [15:0] out1R;
    logic [15:0] out1I;
    logic        outValid;
    logic        cpErr;
    logic        resync;
    logic        busy;
    logic [6:0]  bitCount;

    modport master (
        output serialIn, inValid, frameStart,
        input  out0R, out0I, out1R, out1I, outValid, cpErr, resync, busy, bitCount
    );

    modport slave (
        input  serialIn, inValid, frameStart,
        output out0R, out0I, out1R, out1I, outValid, cpErr, resync, busy, bitCount
    );
endinterface

// File: rtl/cp_removal_deserializer.sv
// ---------------------------------------------------------------------------
// cp_removal_deserializer
//   Receive-side counterpart of the CP insertion / serializer. Takes one
//   OFDM frame bit per qualified cycle (MSB first), strips the cyclic prefix,
//   checks it against the data samples it copies, and presents the two
//   complex 16-bit samples as parallel words with a one-cycle valid strobe.
//
//   Wire order: CP samples, sample 0, sample 1; each sample is R then I.
//   CP sample k is a copy of data sample (2-CP_LEN+k).
//
//   Parameters:
//     CP_LEN      cyclic prefix length in complex samples (0..2)
//   Ports:
//     clk         system clock
//     rst         synchronous active-low reset
//     link        slave side of cp_removal_deserializer_if
// ---------------------------------------------------------------------------
module cp_removal_deserializer #(
    parameter int CP_LEN = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    cp_removal_deserializer_if.slave        link
);

    localparam int         FRAME_BITS  = (CP_LEN + 2) * 32;
    localparam logic [6:0] LAST_IDX    = 7'(FRAME_BITS - 1);
    localparam logic [6:0] CP_LAST_IDX = 7'((CP_LEN == 0) ? 0 : CP_LEN * 32 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CP,
        S_DATA,
        S_DONE
    } state_t;

    // Bit 0 of a frame lands in the CP shifter unless there is no prefix.
    localparam state_t FIRST_STATE = (CP_LEN == 0) ? S_DATA : S_CP;

    state_t      state;
    state_t      next_state;

    logic [6:0]  bit_cnt;
    logic [30:0] cp_sr;          // last 31 CP bits; the 32nd arrives on serialIn
    logic [31:0] cp_buf [2];
    logic [62:0] data_sr;        // last 63 data bits; the 64th arrives on serialIn

    logic [31:0] cp_word;
    logic [63:0] data_next;

    logic        start;          // accept this bit as bit 0 of a new frame
    logic        abort;          // a frame in progress is being abandoned
    logic        take;           // accept this bit as a continuation bit
    logic        last_bit;       // this bit completes the frame
    logic        shift_cp;
    logic        shift_data;
    logic        cp_mismatch;

    logic [15:0] out0_r;
    logic [15:0] out0_i;
    logic [15:0] out1_r;
    logic [15:0] out1_i;
    logic        out_valid;
    logic        cp_err;
    logic        resync_q;

    assign cp_word   = {cp_sr, link.serialIn};
    assign data_next = {data_sr, link.serialIn};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, whatever the block order.
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // through the block can leave one unassigned and infer a latch.
        next_state = state;
        start      = 1'b0;
        abort      = 1'b0;
        take       = 1'b0;
        last_bit   = 1'b0;

        case (state)
            S_IDLE: begin
                if (link.inValid && link.frameStart) begin
                    start      = 1'b1;
                    next_state = FIRST_STATE;
                end
            end

            S_CP, S_DATA: begin
                if (link.inValid) begin
                    if (link.frameStart) begin
                        // A fresh frameStart wins over the frame in progress,
                        // including on what would have been its last bit.
                        start      = 1'b1;
                        abort      = 1'b1;
                        next_state = FIRST_STATE;
                    end else begin
                        take = 1'b1;
                        if (state == S_CP && bit_cnt == CP_LAST_IDX) begin
                            next_state = S_DATA;
                        end
                        if (state == S_DATA && bit_cnt == LAST_IDX) begin
                            last_bit   = 1'b1;
                            next_state = S_DONE;
                        end
                    end
                end
            end

            // Output cycle: nothing is accepted, frameStart is ignored.
            S_DONE:  next_state = S_IDLE;

            default: next_state = S_IDLE;
        endcase
    end

    assign shift_cp   = (start && (FIRST_STATE == S_CP))   || (take && state == S_CP);
    assign shift_data = (start && (FIRST_STATE == S_DATA)) || (take && state == S_DATA);

    // CP buffer k must equal data sample (2-CP_LEN+k); the comparison uses the
    // data word including the bit being accepted now.
    always_comb begin
        cp_mismatch = 1'b0;
        if (CP_LEN == 1) begin
            cp_mismatch = (cp_buf[0] != data_next[31:0]);
        end else if (CP_LEN == 2) begin
            cp_mismatch = (cp_buf[0] != data_next[63:32]) ||
                          (cp_buf[1] != data_next[31:0]);
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt   <= '0;
            cp_sr     <= '0;
            // NOTE: the CP buffer is only two words of flops, so it is reset
            // with everything else rather than left to power-up contents.
            cp_buf[0] <= '0;
            cp_buf[1] <= '0;
            data_sr   <= '0;
            out0_r    <= '0;
            out0_i    <= '0;
            out1_r    <= '0;
            out1_i    <= '0;
            out_valid <= 1'b0;
            cp_err    <= 1'b0;
            resync_q  <= 1'b0;
        end else begin
            out_valid <= last_bit;
            resync_q  <= abort;

            // bit_cnt is the index of the next bit to accept; it drops back
            // to 0 on the last bit so it reads 0 in DONE and IDLE.
            if (start) begin
                bit_cnt <= 7'd1;
            end else if (take) begin
                bit_cnt <= last_bit ? 7'd0 : bit_cnt + 7'd1;
            end

            if (shift_cp) begin
                cp_sr <= cp_word[30:0];
                if (bit_cnt[4:0] == 5'd31) begin
                    cp_buf[bit_cnt[5]] <= cp_word;
                end
            end

            if (shift_data) begin
                data_sr <= data_next[62:0];
            end

            if (last_bit) begin
                out0_r <= data_next[63:48];
                out0_i <= data_next[47:32];
                out1_r <= data_next[31:16];
                out1_i <= data_next[15:0];
                cp_err <= cp_mismatch;
            end
        end
    end

    assign link.out0R    = out0_r;
    assign link.out0I    = out0_i;
    assign link.out1R    = out1_r;
    assign link.out1I    = out1_i;
    assign link.outValid = out_valid;
    assign link.cpErr    = cp_err;
    assign link.resync   = resync_q;
    assign link.busy     = (state != S_IDLE);
    assign link.bitCount = bit_cnt;

endmodule

// File: tb/tb_cp_removal_deserializer.sv
// ---------------------------------------------------------------------------
// tb_cp_removal_deserializer
//   Directed bench for cp_removal_deserializer. Three instances (CP_LEN 0, 1
//   and 2) share one serial driver; each step checks the instance whose
//   frame format the stimulus matches. Expected values are hand-computed
//   frame constants.
// ---------------------------------------------------------------------------
module tb_cp_removal_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic serial;
    logic in_valid;
    logic frame_start;

    int n_pass  = 0;
    int n_total = 0;

    // outValid / resync pulse counters, sampled mid-cycle.
    int ov0 = 0;
    int ov1 = 0;
    int ov2 = 0;
    int rs1 = 0;

    cp_removal_deserializer_if if0 ();
    cp_removal_deserializer_if if1 ();
    cp_removal_deserializer_if if2 ();

    assign if0.serialIn   = serial;
    assign if0.inValid    = in_valid;
    assign if0.frameStart = frame_start;
    assign if1.serialIn   = serial;
    assign if1.inValid    = in_valid;
    assign if1.frameStart = frame_start;
    assign if2.serialIn   = serial;
    assign if2.inValid    = in_valid;
    assign if2.frameStart = frame_start;

    cp_removal_deserializer #(.CP_LEN(0)) dut0 (.clk(clk), .rst(rst), .link(if0));
    cp_removal_deserializer #(.CP_LEN(1)) dut1 (.clk(clk), .rst(rst), .link(if1));
    cp_removal_deserializer #(.CP_LEN(2)) dut2 (.clk(clk), .rst(rst), .link(if2));

    always @(negedge clk) if (if0.outValid) ov0++;
    always @(negedge clk) if (if1.outValid) ov1++;
    always @(negedge clk) if (if2.outValid) ov2++;
    always @(negedge clk) if (if1.resync)   rs1++;

    // Frames, left-aligned: bit i of the frame is f[127-i].
    localparam logic [127:0] F1    = {16'h1D51, 16'h2551, 16'h0D51, 16'h1551,
                                      16'h1D51, 16'h2551, 32'h0};
    localparam logic [127:0] F1BAD = {16'h1D50, 16'h2551, 16'h0D51, 16'h1551,
                                      16'h1D51, 16'h2551, 32'h0};
    localparam logic [127:0] F0    = {16'h0D51, 16'h1551, 16'h1D51, 16'h2551, 64'h0};
    localparam logic [127:0] F2    = {16'h0D51, 16'h1551, 16'h1D51, 16'h2551,
                                      16'h0D51, 16'h1551, 16'h1D51, 16'h2551};
    localparam logic [63:0]  EXP   = 64'h0D51_1551_1D51_2551;

    // ---------------- observation helpers ----------------
    function automatic logic [63:0] outs(input int sel);
        case (sel)
            0:       return {if0.out0R, if0.out0I, if0.out1R, if0.out1I};
            1:       return {if1.out0R, if1.out0I, if1.out1R, if1.out1I};
            default: return {if2.out0R, if2.out0I, if2.out1R, if2.out1I};
        endcase
    endfunction

    function automatic logic ov(input int sel);
        case (sel)
            0:       return if0.outValid;
            1:       return if1.outValid;
            default: return if2.outValid;
        endcase
    endfunction

    function automatic logic ce(input int sel);
        case (sel)
            0:       return if0.cpErr;
            1:       return if1.cpErr;
            default: return if2.cpErr;
        endcase
    endfunction

    function automatic logic rs(input int sel);
        case (sel)
            0:       return if0.resync;
            1:       return if1.resync;
            default: return if2.resync;
        endcase
    endfunction

    function automatic logic bz(input int sel);
        case (sel)
            0:       return if0.busy;
            1:       return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic logic [6:0] bc(input int sel);
        case (sel)
            0:       return if0.bitCount;
            1:       return if1.bitCount;
            default: return if2.bitCount;
        endcase
    endfunction

    // ---------------- check and drive tasks ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid    = 1'b0;
        frame_start = 1'b0;
        repeat (n) tick();
    endtask

    // Sends bits 0..stop-1 of frame f (stop = nbits, or stop_at if >= 0).
    // With gaps set, inValid drops for 3 cycles after every 7th bit while
    // frameStart is held high, which must have no effect.
    task automatic send_bits(input logic [127:0] f, input int nbits, input int sel,
                             input bit gaps, input int stop_at, input logic exp_rs);
        int stop;
        stop = (stop_at >= 0) ? stop_at : nbits;
        for (int i = 0; i < stop; i++) begin
            serial      = f[127 - i];
            in_valid    = 1'b1;
            frame_start = (i == 0);
            tick();
            if (i == 0) check("resync_on_start", rs(sel), exp_rs);
            if (i == nbits - 2) begin
                check("bitcount_max", bc(sel), nbits - 1);
                check("no_early_valid", ov(sel), 1'b0);
            end
            if (gaps && (i % 7 == 6) && (i < nbits - 1)) begin
                in_valid    = 1'b0;
                frame_start = 1'b1;
                for (int g = 0; g < 3; g++) begin
                    serial = ~serial;
                    tick();
                    check("bitcount_frozen", bc(sel), i + 1);
                end
            end
        end
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int sel,
                               input logic [63:0] exp_word, input logic exp_err);
        check({tag, "_valid"}, ov(sel), 1'b1);
        check({tag, "_data"},  outs(sel), exp_word);
        check({tag, "_cperr"}, ce(sel), exp_err);
        check({tag, "_busy"},  bz(sel), 1'b1);
        check({tag, "_count"}, bc(sel), 7'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ov_b;
        int rs_b;

        rst         = 1'b0;
        serial      = 1'b0;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        tick();
        tick();

        // Reset state
        check("reset_data",  outs(1), 64'h0);
        check("reset_valid", ov(1), 1'b0);
        check("reset_busy",  bz(1), 1'b0);
        check("reset_count", bc(1), 7'd0);
        check("reset_data2", outs(2), 64'h0);
        rst = 1'b1;
        idle(1);

        // 1: clean CP_LEN=1 frame, then frameStart during DONE is ignored
        send_bits(F1, 96, 1, 1'b0, -1, 1'b0);
        check_frame("t1", 1, EXP, 1'b0);
        serial      = 1'b1;
        in_valid    = 1'b1;
        frame_start = 1'b1;
        tick();
        check("done_fs_busy",  bz(1), 1'b0);
        check("done_fs_count", bc(1), 7'd0);
        check("valid_one_cycle", ov(1), 1'b0);
        idle(1);

        // 2: corrupted CP word
        send_bits(F1BAD, 96, 1, 1'b0, -1, 1'b0);
        check_frame("t2", 1, EXP, 1'b1);
        idle(1);

        // 3: clean frame with inValid gaps
        send_bits(F1, 96, 1, 1'b1, -1, 1'b0);
        check_frame("t3", 1, EXP, 1'b0);
        idle(1);

        // 4: abort at bit 40, then a clean frame
        ov_b = ov1;
        rs_b = rs1;
        send_bits(F1BAD, 96, 1, 1'b0, 40, 1'b0);
        send_bits(F1, 96, 1, 1'b0, -1, 1'b1);
        check_frame("t4", 1, EXP, 1'b0);
        idle(1);
        check("t4_valid_count",  ov1 - ov_b, 1);
        check("t4_resync_count", rs1 - rs_b, 1);

        // 5: reset at bit 50, then a clean frame
        ov_b = ov1;
        send_bits(F1BAD, 96, 1, 1'b0, 50, 1'b0);
        rst = 1'b0;
        tick();
        check("t5_rst_data",   outs(1), 64'h0);
        check("t5_rst_valid",  ov(1), 1'b0);
        check("t5_rst_cperr",  ce(1), 1'b0);
        check("t5_rst_resync", rs(1), 1'b0);
        check("t5_rst_busy",   bz(1), 1'b0);
        check("t5_rst_count",  bc(1), 7'd0);
        rst = 1'b1;
        idle(1);
        send_bits(F1, 96, 1, 1'b0, -1, 1'b0);
        check_frame("t5", 1, EXP, 1'b0);
        idle(1);
        check("t5_valid_count", ov1 - ov_b, 1);

        // 6a: CP_LEN=0
        ov_b = ov0;
        send_bits(F0, 64, 0, 1'b0, -1, 1'b0);
        check_frame("t6_cp0", 0, EXP, 1'b0);
        idle(1);
        check("t6_cp0_valid_count", ov0 - ov_b, 1);

        // 6b: CP_LEN=2 (reset first: instance 2 holds partial frames)
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(1);
        ov_b = ov2;
        send_bits(F2, 128, 2, 1'b0, -1, 1'b0);
        check_frame("t6_cp2", 2, EXP, 1'b0);
        idle(1);
        check("t6_cp2_valid_count", ov2 - ov_b, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
